// File: rtl/i2c_pkg.sv
// Shared I2C definitions: sequencer state encoding and default widths,
// used by the byte master and the clock generator.
package i2c_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ACK_A,
        WRITE,
        ACK_W,
        READ,
        MACK,
        STOP
    } state_t;

endpackage

// File: rtl/i2c_byte_master_if.sv
// Host handshake plus I2C phase/line signals of the byte master.
// master = the sequencer side, slave = host / clock generator / pad side.
interface i2c_byte_master_if #(
    parameter int ADDR_W = i2c_pkg::ADDR_W_DEF,
    parameter int DATA_W = i2c_pkg::DATA_W_DEF
);
    logic              data_clk;
    logic              sda_in;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wdata;
    logic              scl_not_ena;
    logic              sda_oe;
    logic              busy;
    logic              done;
    logic              ack_err;
    logic [DATA_W-1:0] rdata;

    modport master (
        input  data_clk, sda_in, start, addr, rw, wdata,
        output scl_not_ena, sda_oe, busy, done, ack_err, rdata
    );

    modport slave (
        output data_clk, sda_in, start, addr, rw, wdata,
        input  scl_not_ena, sda_oe, busy, done, ack_err, rdata
    );
endinterface

// File: rtl/i2c_phase_edge.sv
// Edge detector on the clock generator's data_clk phase signal.
// rise/fall are registered single-cycle pulses.
module i2c_phase_edge (
    input  logic clk,
    input  logic rst,
    input  logic data_clk,
    output logic rise,
    output logic fall
);
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            prev <= data_clk;
            rise <= data_clk & ~prev;
            fall <= ~data_clk & prev;
        end
    end
endmodule

// File: rtl/i2c_byte_master.sv
// Single-byte I2C master: START, addr+R/W, one data byte, ACK/NACK, STOP.
// Read path (READ/MACK) is built only when I2C_MASTER_READ_EN is defined.
module i2c_byte_master
    import i2c_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input logic               clk,
    input logic               rst,
    i2c_byte_master_if.master bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t            state;
    logic              rise, fall;
    logic [ADDR_W:0]   sh;
    logic [DATA_W-1:0] wd;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic              scl_not_ena, sda_oe, busy, done, ack_err;
    logic              rw_in;

`ifdef I2C_MASTER_READ_EN
    logic              rw_q;
    logic [DATA_W-1:0] rdata;
    assign rw_in     = bus.rw;
    assign bus.rdata = rdata;
`else
    logic unused_rw;
    assign unused_rw = bus.rw;
    assign rw_in     = 1'b0;
    assign bus.rdata = '0;
`endif

    assign bus.scl_not_ena = scl_not_ena;
    assign bus.sda_oe      = sda_oe;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.ack_err     = ack_err;

    i2c_phase_edge u_edge (
        .clk      (clk),
        .rst      (rst),
        .data_clk (bus.data_clk),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sh          <= '0;
            wd          <= '0;
            cnt         <= '0;
            last        <= 1'b0;
            scl_not_ena <= 1'b1;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
`ifdef I2C_MASTER_READ_EN
            rw_q        <= 1'b0;
            rdata       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    sh      <= {bus.addr, rw_in};
                    wd      <= bus.wdata;
`ifdef I2C_MASTER_READ_EN
                    rw_q    <= bus.rw;
`endif
                    ack_err <= 1'b0;
                    busy    <= 1'b1;
                    state   <= START;
                end
                START: if (fall) begin
                    sda_oe      <= 1'b1;
                    scl_not_ena <= 1'b0;
                    cnt         <= CNT_W'(ADDR_W);
                    last        <= 1'b0;
                    state       <= ADDR;
                end
                // last marks "bit 0 already on the wire"; the next rise releases SDA
                ADDR: if (rise) begin
                    if (last) begin
                        sda_oe <= 1'b0;
                        state  <= ACK_A;
                    end else begin
                        sda_oe <= ~sh[ADDR_W];
                        sh     <= {sh[ADDR_W-1:0], 1'b0};
                        if (cnt == '0) last <= 1'b1;
                        else           cnt  <= cnt - 1'b1;
                    end
                end
                ACK_A: if (fall) begin
                    last <= 1'b0;
                    if (bus.sda_in) begin
                        ack_err <= 1'b1;
                        state   <= STOP;
`ifdef I2C_MASTER_READ_EN
                    end else if (rw_q) begin
                        cnt   <= CNT_W'(DATA_W);
                        state <= READ;
`endif
                    end else begin
                        cnt   <= CNT_W'(DATA_W - 1);
                        state <= WRITE;
                    end
                end
                WRITE: if (rise) begin
                    if (last) begin
                        sda_oe <= 1'b0;
                        state  <= ACK_W;
                    end else begin
                        sda_oe <= ~wd[DATA_W-1];
                        wd     <= {wd[DATA_W-2:0], 1'b0};
                        if (cnt == '0) last <= 1'b1;
                        else           cnt  <= cnt - 1'b1;
                    end
                end
                ACK_W: if (fall) begin
                    if (bus.sda_in) ack_err <= 1'b1;
                    state <= STOP;
                end
`ifdef I2C_MASTER_READ_EN
                READ: if (fall) begin
                    rdata <= {rdata[DATA_W-2:0], bus.sda_in};
                    cnt   <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= MACK;
                end
                // Single-byte reads always end with a master NACK
                MACK: begin
                    if (rise)      sda_oe <= 1'b0;
                    else if (fall) state  <= STOP;
                end
`endif
                STOP: begin
                    if (rise) begin
                        sda_oe <= 1'b1;
                    end else if (fall) begin
                        sda_oe      <= 1'b0;
                        scl_not_ena <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: table vectors, hand sequences, random transactions
// checked against a bit-list model of the SDA wire as seen at each SCL-high phase.
module tb_i2c_byte_master;
    import i2c_pkg::*;

    localparam int AW   = 7;
    localparam int DW   = 8;
    localparam int HALF = 4;
`ifdef I2C_MASTER_READ_EN
    localparam bit RD_ON = 1'b1;
`else
    localparam bit RD_ON = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic          rw;
        logic [DW-1:0] wdata;
        logic          nack_a;
        logic          nack_w;
        logic [DW-1:0] rd;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    logic clk;
    logic rst;
    logic tgt;

    i2c_byte_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    assign bus.sda_in = tgt & ~bus.sda_oe;

    i2c_byte_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int dcnt;
    logic err_at_done, busy_at_done;
    logic [DW-1:0] rdata_at_done;
    bit wire_q[$];
    bit exp_q[$];
    logic cur_nack_a, cur_nack_w, cur_rw;
    logic [DW-1:0] rd_sh;
    logic [DW-1:0] rd_model;
    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] p = '0;
        foreach (q[i]) p = {p[30:0], q[i]};
        p[31:24] = 8'(q.size());
        return p;
    endfunction

    // Expected SDA pull-down level at each SCL-high phase after START
    function automatic void build_exp(input vec_t v);
        logic [AW:0]   ar;
        logic [DW-1:0] wd;
        logic          rwe;
        rwe = v.rw & RD_ON;
        ar  = {v.addr, rwe};
        wd  = v.wdata;
        exp_q.delete();
        for (int i = 0; i <= AW; i++) begin
            exp_q.push_back(~ar[AW]);
            ar = ar << 1;
        end
        exp_q.push_back(1'b0);
        if (!v.nack_a) begin
            for (int i = 0; i < DW; i++) begin
                exp_q.push_back(rwe ? 1'b0 : ~wd[DW-1]);
                wd = wd << 1;
            end
            exp_q.push_back(1'b0);
        end
        exp_q.push_back(1'b1);
    endfunction

    task automatic tick();
        @(negedge clk);
        if (bus.done) begin
            dcnt++;
            err_at_done   = bus.ack_err;
            busy_at_done  = bus.busy;
            rdata_at_done = bus.rdata;
        end
    endtask

    // One data_clk half period; the bench plays the target on each rise
    task automatic half();
        int k;
        if (bus.data_clk) begin
            if (!bus.scl_not_ena) wire_q.push_back(bus.sda_oe);
        end else begin
            k   = wire_q.size() + 1;
            tgt = 1'b1;
            if (k == AW + 2) begin
                tgt = cur_nack_a;
            end else if (!cur_nack_a && cur_rw && k >= AW + 3 && k <= AW + 2 + DW) begin
                tgt   = rd_sh[DW-1];
                rd_sh = rd_sh << 1;
            end else if (!cur_nack_a && !cur_rw && k == AW + DW + 3) begin
                tgt = cur_nack_w;
            end
        end
        bus.data_clk = ~bus.data_clk;
        repeat (HALF) tick();
    endtask

    task automatic begin_txn(input vec_t v);
        cur_nack_a = v.nack_a;
        cur_nack_w = v.nack_w;
        cur_rw     = v.rw & RD_ON;
        rd_sh      = v.rd;
        wire_q.delete();
        dcnt      = 0;
        bus.addr  = v.addr;
        bus.rw    = v.rw;
        bus.wdata = v.wdata;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input bit poke, input string tag);
        bit poked = 1'b0;
        build_exp(v);
        begin_txn(v);
        check({tag, ".busy_accept"}, 32'(bus.busy), 1);
        for (int h = 0; h < 80 && dcnt == 0; h++) begin
            if (poke && !poked && wire_q.size() == 5) begin
                bus.start = 1'b1;
                bus.addr  = ~v.addr;
                tick();
                bus.start = 1'b0;
                poked     = 1'b1;
            end
            half();
        end
        repeat (6) half();
        check({tag, ".done_count"}, 32'(dcnt), 1);
        check({tag, ".wire"}, pack(wire_q), pack(exp_q));
        check({tag, ".ack_err"}, 32'(err_at_done), 32'(v.exp_err));
        check({tag, ".rdata"}, 32'(rdata_at_done), 32'(v.exp_rdata));
        check({tag, ".busy_at_done"}, 32'(busy_at_done), 0);
        check({tag, ".idle_lines"}, {30'd0, bus.scl_not_ena, bus.sda_oe}, 32'h2);
        rd_model = v.exp_rdata;
    endtask

    initial begin
        vec_t v;
        rst          = 1'b1;
        tgt          = 1'b1;
        bus.data_clk = 1'b0;
        bus.start    = 1'b0;
        bus.addr     = '0;
        bus.rw       = 1'b0;
        bus.wdata    = '0;
        rd_model     = '0;
        dcnt         = 0;

        tbl[0] = '{7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        tbl[1] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        tbl[2] = '{7'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 8'h96, 1'b0, RD_ON ? 8'h96 : 8'h00};
        tbl[3] = '{7'h7F, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, RD_ON ? 8'h96 : 8'h00};
        tbl[4] = '{7'h01, 1'b1, 8'h5A, 1'b1, 1'b0, 8'hFF, 1'b1, RD_ON ? 8'h96 : 8'h00};
        tbl[5] = '{7'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, RD_ON ? 8'h96 : 8'h00};
        tbl[6] = '{7'h55, 1'b1, 8'h81, 1'b0, 1'b1, 8'h00, RD_ON ? 1'b0 : 1'b1, 8'h00};

        repeat (3) tick();
        check("reset.scl_not_ena", 32'(bus.scl_not_ena), 1);
        check("reset.sda_oe", 32'(bus.sda_oe), 0);
        check("reset.busy", 32'(bus.busy), 0);
        check("reset.done", 32'(bus.done), 0);
        check("reset.ack_err", 32'(bus.ack_err), 0);
        check("reset.rdata", 32'(bus.rdata), 0);
        rst = 1'b0;
        tick();

        // Reset while data bit 3 (0 on the wire, SDA pulled low) is driven
        v = '{7'h2A, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
        begin_txn(v);
        for (int h = 0; h < 80 && !(wire_q.size() == AW + 6 && bus.data_clk); h++) half();
        check("rst_mid.pre_sda_oe", 32'(bus.sda_oe), 1);
        rst = 1'b1;
        tick();
        check("rst_mid.sda_oe", 32'(bus.sda_oe), 0);
        check("rst_mid.scl_not_ena", 32'(bus.scl_not_ena), 1);
        check("rst_mid.busy", 32'(bus.busy), 0);
        check("rst_mid.ack_err", 32'(bus.ack_err), 0);
        rst = 1'b0;
        repeat (10) half();
        check("rst_mid.no_done", 32'(dcnt), 0);
        check("rst_mid.no_more_bits", 32'(wire_q.size()), AW + 6);
        rd_model = '0;

        for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        v = '{7'h12, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, rd_model};
        run_txn(v, 1'b1, "start_while_busy");

        for (int i = 0; i < 16; i++) begin
            v.addr   = AW'($urandom);
            v.rw     = 1'($urandom);
            v.wdata  = DW'($urandom);
            v.nack_a = ($urandom_range(0, 3) == 0);
            v.nack_w = ($urandom_range(0, 3) == 0);
            v.rd     = DW'($urandom);
            v.exp_err   = v.nack_a | (~(v.rw & RD_ON) & v.nack_w);
            v.exp_rdata = ((v.rw & RD_ON) && !v.nack_a) ? v.rd : rd_model;
            run_txn(v, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
